// File: rtl/shifter_dmasnd_if.sv
// Sound DMA bus between the MCU (master) and the shifter sound receiver (slave).
interface shifter_dmasnd_if;
    logic        sload_n;
    logic [15:0] din;
    logic        sreq;

    modport master (output sload_n, output din, input sreq);
    modport slave  (input sload_n, input din, output sreq);
endinterface

// File: rtl/shifter_dmasnd.sv
// Shifter-side DMA-sound receiver: buffers MCU sound words and plays them out as 8-bit samples.
// Optional macro SND_UNDERRUN_ZERO_EN: an underrun tick outputs silence instead of holding.
module shifter_dmasnd #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk32,
    input  logic            porb,
    input  logic            mhz8_en,
    input  logic            sndon,
    input  logic            stereo,
    input  logic [1:0]      rate,
    shifter_dmasnd_if.slave bus,
    output logic [7:0]      left,
    output logic [7:0]      right,
    output logic            stick,
    output logic            ovf,
    output logic            unf
);

    localparam logic [0:0] PH_HI = 1'b0;
    localparam logic [0:0] PH_LO = 1'b1;

    localparam logic [PTRW:0] CNT_FULL = (PTRW + 1)'(DEPTH);
    localparam logic [PTRW:0] CNT_REQ  = (PTRW + 1)'(DEPTH - 2);
    localparam logic [PTRW:0] CNT_ONE  = (PTRW + 1)'(1);
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

    logic [2:0]      sl_q;
    logic [15:0]     din_q;
    logic [15:0]     mem_q [DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW:0]   count_q, count_d;
    logic [10:0]     div_q, div_d;
    logic [10:0]     reload;
    logic            stick_q, stick_d;
    logic            sreq_q, sreq_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [0:0]      phase_q, phase_d;
    logic [7:0]      left_q, left_d;
    logic [7:0]      right_q, right_d;

    logic            empty, full, load_fall, push, pop;
    logic [15:0]     head;

    always_comb begin
        unique case (rate)
            2'b00: reload = 11'd1279;
            2'b01: reload = 11'd639;
            2'b10: reload = 11'd319;
            2'b11: reload = 11'd159;
        endcase
    end

    // sl_q[1] is the synchronised strobe, sl_q[2] its previous value
    assign load_fall = sndon & sl_q[2] & ~sl_q[1];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign head      = mem_q[rd_ptr_q];
    assign pop       = sndon & stick_q & ~empty & (stereo | (phase_q == PH_LO));
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push      = load_fall & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        div_d    = div_q;
        stick_d  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        phase_d  = phase_q;
        left_d   = left_q;
        right_d  = right_q;
        sreq_d   = sndon & (count_q <= CNT_REQ);

        if (!sndon) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            div_d    = reload;
            phase_d  = PH_HI;
            left_d   = '0;
            right_d  = '0;
        end else begin
            if (mhz8_en) begin
                if (div_q == '0) begin
                    div_d   = reload;
                    stick_d = 1'b1;
                end else begin
                    div_d = div_q - 11'd1;
                end
            end

            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;

            if (load_fall && full && !pop) ovf_d = 1'b1;

            if (stick_q) begin
                if (empty) begin
                    unf_d = 1'b1;
`ifdef SND_UNDERRUN_ZERO_EN
                    left_d  = '0;
                    right_d = '0;
`else
                    left_d  = left_q;
                    right_d = right_q;
`endif
                end else if (stereo) begin
                    left_d  = head[15:8];
                    right_d = head[7:0];
                end else if (phase_q == PH_HI) begin
                    left_d  = head[15:8];
                    right_d = head[15:8];
                    phase_d = PH_LO;
                end else begin
                    left_d  = head[7:0];
                    right_d = head[7:0];
                    phase_d = PH_HI;
                end
            end
        end
    end

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            sl_q  <= '1;
            din_q <= '0;
        end else begin
            sl_q  <= {sl_q[1:0], bus.sload_n};
            din_q <= bus.din;
        end
    end

    always_ff @(posedge clk32) begin
        if (push) mem_q[wr_ptr_q] <= din_q;
    end

    always_ff @(posedge clk32 or negedge porb) begin
        if (!porb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            div_q    <= 11'd1279;
            stick_q  <= 1'b0;
            sreq_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            phase_q  <= PH_HI;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            stick_q  <= stick_d;
            sreq_q   <= sreq_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            phase_q  <= phase_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign bus.sreq = sreq_q;
    assign left     = left_q;
    assign right    = right_q;
    assign stick    = stick_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_shifter_dmasnd.sv
// Self-checking bench for shifter_dmasnd against a queue-based sample playback model.
`timescale 1ns/1ps
module tb_shifter_dmasnd;

    localparam int DEPTH = 4;

    logic       clk32 = 1'b0;
    logic       porb;
    logic       mhz8_en;
    logic       sndon;
    logic       stereo;
    logic [1:0] rate;
    logic [7:0] left, right;
    logic       stick, ovf, unf;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mq[$];
    bit          mphase;
    logic [7:0]  mleft, mright;
    bit          movf, munf;

    shifter_dmasnd_if bus();

    shifter_dmasnd #(.DEPTH(DEPTH), .PTRW(2)) dut (
        .clk32   (clk32),
        .porb    (porb),
        .mhz8_en (mhz8_en),
        .sndon   (sndon),
        .stereo  (stereo),
        .rate    (rate),
        .bus     (bus),
        .left    (left),
        .right   (right),
        .stick   (stick),
        .ovf     (ovf),
        .unf     (unf)
    );

    initial forever #5 clk32 = ~clk32;

    // ---------------- reference model ----------------
    task automatic mflush();
        mq.delete();
        mphase = 1'b0;
        mleft  = 8'h00;
        mright = 8'h00;
    endtask

    task automatic mpush(input logic [15:0] w);
        if (mq.size() == DEPTH) movf = 1'b1;
        else mq.push_back(w);
    endtask

    task automatic mtick();
        logic [15:0] w;
        if (mq.size() == 0) begin
            munf = 1'b1;
`ifdef SND_UNDERRUN_ZERO_EN
            mleft  = 8'h00;
            mright = 8'h00;
`endif
        end else if (stereo) begin
            w = mq.pop_front();
            mleft  = w[15:8];
            mright = w[7:0];
        end else if (!mphase) begin
            w = mq[0];
            mleft  = w[15:8];
            mright = w[15:8];
            mphase = 1'b1;
        end else begin
            w = mq.pop_front();
            mleft  = w[7:0];
            mright = w[7:0];
            mphase = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [15:0] w);
        @(negedge clk32);
        bus.din     = w;
        bus.sload_n = 1'b0;
        repeat ($urandom_range(6, 2)) @(negedge clk32);
        bus.sload_n = 1'b1;
        repeat (3) @(negedge clk32);
        bus.din = 16'($urandom);
        if (sndon) mpush(w);
    endtask

    // Pulses mhz8_en until stick appears or maxp pulses are spent; leaves the
    // bench one cycle after stick so the updated sample is visible.
    task automatic run_tick(input int maxp, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < maxp) begin
            @(negedge clk32); mhz8_en = 1'b1;
            @(negedge clk32); mhz8_en = 1'b0;
            n++;
            if (stick === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            @(negedge clk32);
            mtick();
        end
    endtask

    task automatic restart(input logic st, input logic [1:0] r);
        @(negedge clk32);
        sndon  = 1'b0;
        stereo = st;
        rate   = r;
        @(negedge clk32);
        sndon = 1'b1;
        mflush();
        @(negedge clk32);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        porb = 1'b0; sndon = 1'b0; stereo = 1'b1; rate = 2'b11;
        mhz8_en = 1'b0; bus.sload_n = 1'b1; bus.din = '0;
        mflush(); movf = 1'b0; munf = 1'b0;
        repeat (3) @(negedge clk32);
        vectors++;
        if ({bus.sreq, left, right, stick, ovf, unf} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {bus.sreq, left, right, stick, ovf, unf});
        end
        vectors++;
        if (int'(dut.count_q) !== 0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d want 0", dut.count_q);
        end
        porb = 1'b1;
        @(negedge clk32);
        sndon = 1'b1;
        repeat (2) @(negedge clk32);
        vectors++;
        if (bus.sreq !== 1'b1) begin
            miscompares++;
            $display("FAIL sreq_rise: got %b want 1", bus.sreq);
        end
    endtask

    task automatic test_stereo();
        int n; bit seen;
        load(16'h7F80);
        run_tick(200, n, seen);
        vectors++;
        if (!seen || n !== 160) begin
            miscompares++;
            $display("FAIL stereo_first_tick: got seen=%0d pulses=%0d want pulses=160", seen, n);
        end
        vectors++;
        if ({left, right} !== 16'h7F80) begin
            miscompares++;
            $display("FAIL stereo_sample: got %h want 7f80", {left, right});
        end
    endtask

    task automatic test_mono();
        int n; bit seen;
        restart(1'b0, 2'b00);
        load(16'h1234);
        run_tick(1400, n, seen);
        vectors++;
        if (!seen || n !== 1280 || {left, right} !== 16'h1212) begin
            miscompares++;
            $display("FAIL mono_tick1: got seen=%0d pulses=%0d lr=%h want 1280 1212", seen, n, {left, right});
        end
        run_tick(1400, n, seen);
        vectors++;
        if (!seen || n !== 1280 || {left, right} !== 16'h3434) begin
            miscompares++;
            $display("FAIL mono_tick2: got seen=%0d pulses=%0d lr=%h want 1280 3434", seen, n, {left, right});
        end
        vectors++;
        if (int'(dut.count_q) !== 0) begin
            miscompares++;
            $display("FAIL mono_count: got %0d want 0", dut.count_q);
        end
    endtask

    task automatic test_underrun();
        int n; bit seen;
        logic [15:0] want;
`ifdef SND_UNDERRUN_ZERO_EN
        want = 16'h0000;
`else
        want = 16'h3434;
`endif
        run_tick(1400, n, seen);
        vectors++;
        if (!seen || unf !== 1'b1 || {left, right} !== want) begin
            miscompares++;
            $display("FAIL underrun: got seen=%0d unf=%b lr=%h want unf=1 lr=%h", seen, unf, {left, right}, want);
        end
    endtask

    task automatic test_fill_ovf();
        restart(1'b1, 2'b11);
        for (int unsigned i = 0; i < 3; i++) load(16'hA000 + 16'(i));
        vectors++;
        if (bus.sreq !== 1'b0 || int'(dut.count_q) !== 3) begin
            miscompares++;
            $display("FAIL fill3: got sreq=%b count=%0d want 0 3", bus.sreq, dut.count_q);
        end
        load(16'hA003);
        vectors++;
        if (int'(dut.count_q) !== 4 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL fill4: got count=%0d ovf=%b want 4 0", dut.count_q, ovf);
        end
        load(16'hA004);
        vectors++;
        if (int'(dut.count_q) !== 4 || ovf !== 1'b1 || movf !== 1'b1) begin
            miscompares++;
            $display("FAIL fill5_ovf: got count=%0d ovf=%b want 4 1", dut.count_q, ovf);
        end
    endtask

    task automatic test_push_pop_full();
        int n; bit seen;
        run_tick(159, n, seen);
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL early_stick: got stick after %0d pulses want none before 160", n);
        end
        @(negedge clk32); bus.din = 16'hBEEF; bus.sload_n = 1'b0;
        @(negedge clk32); mhz8_en = 1'b1;
        @(negedge clk32); mhz8_en = 1'b0;
        vectors++;
        if (stick !== 1'b1) begin
            miscompares++;
            $display("FAIL coincide_stick: got %b want 1", stick);
        end
        @(negedge clk32);
        mtick();
        mpush(16'hBEEF);
        vectors++;
        if (int'(dut.count_q) !== 4 || {left, right} !== {mleft, mright} || ovf !== movf) begin
            miscompares++;
            $display("FAIL coincide: got count=%0d lr=%h ovf=%b want 4 %h %b",
                     dut.count_q, {left, right}, ovf, {mleft, mright}, movf);
        end
        repeat (2) @(negedge clk32);
        bus.sload_n = 1'b1;
        repeat (3) @(negedge clk32);
        for (int unsigned i = 0; i < 4; i++) begin
            run_tick(200, n, seen);
            vectors++;
            if (!seen || n !== 160 || {left, right} !== {mleft, mright}) begin
                miscompares++;
                $display("FAIL drain_%0d: got seen=%0d pulses=%0d lr=%h want 160 %h",
                         i, seen, n, {left, right}, {mleft, mright});
            end
        end
        vectors++;
        if ({left, right} !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL drain_last: got %h want beef", {left, right});
        end
    endtask

    task automatic test_sndon_drop();
        int n; bit seen;
        for (int unsigned i = 0; i < 3; i++) load(16'(16'h5100 + 16'h0111 * 16'(i)));
        run_tick(200, n, seen);
        @(negedge clk32);
        sndon = 1'b0;
        @(negedge clk32);
        mflush();
        vectors++;
        if (int'(dut.count_q) !== 0 || bus.sreq !== 1'b0 || {left, right} !== 16'h0) begin
            miscompares++;
            $display("FAIL sndon_drop: got count=%0d sreq=%b lr=%h want 0 0 0", dut.count_q, bus.sreq, {left, right});
        end
        vectors++;
        if (ovf !== 1'b1 || unf !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_hold: got ovf=%b unf=%b want 1 1", ovf, unf);
        end
        load(16'hDEAD);
        vectors++;
        if (int'(dut.count_q) !== 0) begin
            miscompares++;
            $display("FAIL load_while_off: got count=%0d want 0", dut.count_q);
        end
        sndon = 1'b1;
        run_tick(200, n, seen);
        vectors++;
        if (!seen || n !== 160 || ovf !== 1'b1 || unf !== 1'b1) begin
            miscompares++;
            $display("FAIL sndon_rise: got seen=%0d pulses=%0d ovf=%b unf=%b want 160 1 1", seen, n, ovf, unf);
        end
    endtask

    task automatic test_random(input logic st);
        int n; bit seen;
        restart(st, 2'b11);
        for (int unsigned i = 0; i < 30; i++) begin
            if ($urandom_range(2, 0) != 0) begin
                load(16'($urandom));
            end else begin
                run_tick(200, n, seen);
                vectors++;
                if (!seen || n !== 160) begin
                    miscompares++;
                    $display("FAIL rand_tick_%0d: got seen=%0d pulses=%0d want 160", i, seen, n);
                end
            end
            @(negedge clk32);
            vectors++;
            if ({left, right} !== {mleft, mright} || ovf !== movf || unf !== munf) begin
                miscompares++;
                $display("FAIL rand_out_%0d: got lr=%h ovf=%b unf=%b want %h %b %b",
                         i, {left, right}, ovf, unf, {mleft, mright}, movf, munf);
            end
            vectors++;
            if (int'(dut.count_q) !== mq.size() || bus.sreq !== (mq.size() <= DEPTH - 2)) begin
                miscompares++;
                $display("FAIL rand_fifo_%0d: got count=%0d sreq=%b want %0d %b",
                         i, dut.count_q, bus.sreq, mq.size(), (mq.size() <= DEPTH - 2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stereo();
        test_mono();
        test_underrun();
        test_fill_ovf();
        test_push_pop_full();
        test_sndon_drop();
        test_random(1'b1);
        test_random(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
